// File: rtl/single_port_ram_pkg.sv
// Shared sizing constants and word/address types for the 128 x 8 scratch RAM.
package single_port_ram_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/spram_array.sv
// Storage array: synchronous whole-array clear, clocked write, and an
// unregistered read port that always reflects current contents.
module spram_array
  import single_port_ram_pkg::*;
#(
  parameter int ADDR_W = single_port_ram_pkg::ADDR_W,
  parameter int DATA_W = single_port_ram_pkg::DATA_W,
  parameter int DEPTH  = single_port_ram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_write_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_read_addr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Reset wins over a write presented on the same edge.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_write_addr] <= i_data;
    end
  end

  assign o_rdata = r_mem[i_read_addr];
endmodule

// File: rtl/single_port_ram.sv
// 128 x 8 RAM with registered (q) and combinational (y) read of read_addr.
// Define SINGLE_PORT_RAM_BYPASS_EN for write-through on q during a same-address write.
module single_port_ram
  import single_port_ram_pkg::*;
#(
  parameter int ADDR_W = single_port_ram_pkg::ADDR_W,
  parameter int DATA_W = single_port_ram_pkg::DATA_W,
  parameter int DEPTH  = single_port_ram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] y
);
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_q;

  spram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk          (clk),
    .i_rst        (rst),
    .i_we         (we),
    .i_write_addr (write_addr),
    .i_data       (data),
    .i_read_addr  (read_addr),
    .o_rdata      (w_rdata)
  );

  // w_rdata is the pre-edge word, so capturing it gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
`ifdef SINGLE_PORT_RAM_BYPASS_EN
      if (we && (write_addr == read_addr)) begin
        r_q <= data;
      end else begin
        r_q <= w_rdata;
      end
`else
      r_q <= w_rdata;
`endif
    end
  end

  assign q = r_q;
  assign y = w_rdata;
endmodule

// File: tb/tb_single_port_ram.sv
// Directed plus randomized checks of single_port_ram against an array model.
module tb_single_port_ram;
  import single_port_ram_pkg::*;

  logic  clk;
  logic  rst;
  logic  we;
  addr_t write_addr;
  addr_t read_addr;
  data_t data;
  data_t q;
  data_t y;

  int vectors;
  int miscompares;

  data_t model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  single_port_ram dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .write_addr (write_addr),
    .read_addr  (read_addr),
    .data       (data),
    .q          (q),
    .y          (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input data_t observed, input data_t expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock edge with the given inputs; model updated, outputs checked at negedge.
  task automatic apply_edge(input logic rst_v, input logic we_v, input addr_t wa,
                            input addr_t ra, input data_t d, input string tag);
    data_t want_q;
    rst        = rst_v;
    we         = we_v;
    write_addr = wa;
    read_addr  = ra;
    data       = d;
    @(posedge clk);
    if (rst_v) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      exp_q.push_back('0);
    end else begin
`ifdef SINGLE_PORT_RAM_BYPASS_EN
      want_q = (we_v && wa == ra) ? d : model_mem[ra];
`else
      want_q = model_mem[ra];
`endif
      exp_q.push_back(want_q);
      if (we_v) model_mem[wa] = d;
    end
    @(negedge clk);
    check({tag, ".q"}, q, exp_q.pop_front());
    check({tag, ".y"}, y, model_mem[ra]);
  endtask

  // Change read_addr between edges; y must follow without a clock.
  task automatic peek_y(input addr_t ra, input string tag);
    read_addr = ra;
    we        = 1'b0;
    #1;
    check(tag, y, model_mem[ra]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; we = 1'b0; write_addr = '0; read_addr = '0; data = '0;

    apply_edge(1'b1, 1'b0, 7'd0, 7'd0, 8'h00, "reset_a0");
    peek_y(7'd127, "reset_y127");
    apply_edge(1'b0, 1'b0, 7'd0, 7'd127, 8'h00, "reset_a127");

    apply_edge(1'b0, 1'b1, 7'd10, 7'd20, 8'hAB, "plain_wr");
    peek_y(7'd10, "plain_y_now");
    apply_edge(1'b0, 1'b0, 7'd0, 7'd10, 8'h00, "plain_rd");

    apply_edge(1'b1, 1'b0, 7'd0, 7'd10, 8'h00, "reset2");
    apply_edge(1'b0, 1'b1, 7'd10, 7'd10, 8'hAB, "collide");
    apply_edge(1'b0, 1'b0, 7'd0, 7'd10, 8'h00, "collide_next");

    for (int i = 0; i < 3; i++) apply_edge(1'b0, 1'b0, 7'd10, 7'd10, 8'h55, "we0_hold");

    apply_edge(1'b0, 1'b1, 7'd0, 7'd1, 8'h01, "bnd_wr0");
    apply_edge(1'b0, 1'b1, 7'd127, 7'd126, 8'hFE, "bnd_wr127");
    apply_edge(1'b0, 1'b0, 7'd0, 7'd0, 8'h00, "bnd_rd0");
    apply_edge(1'b0, 1'b0, 7'd0, 7'd127, 8'h00, "bnd_rd127");
    apply_edge(1'b0, 1'b0, 7'd0, 7'd1, 8'h00, "bnd_rd1");
    apply_edge(1'b0, 1'b0, 7'd0, 7'd126, 8'h00, "bnd_rd126");

    apply_edge(1'b0, 1'b1, 7'd10, 7'd10, 8'hAB, "mid_wr");
    apply_edge(1'b1, 1'b1, 7'd10, 7'd10, 8'hCD, "mid_rst");
    apply_edge(1'b0, 1'b0, 7'd0, 7'd10, 8'h00, "mid_after");

    // Narrow address window keeps collisions and read-after-write frequent.
    for (int n = 0; n < 300; n++) begin
      logic  r_v, w_v;
      addr_t wa, ra;
      r_v = ($urandom_range(0, 49) == 0);
      w_v = ($urandom_range(0, 2) != 0);
      wa  = addr_t'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? wa : addr_t'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) wa = addr_t'($urandom_range(0, DEPTH - 1));
      apply_edge(r_v, w_v, wa, ra, data_t'($urandom_range(0, 255)), "rand");
      if ($urandom_range(0, 9) == 0) peek_y(addr_t'($urandom_range(0, 15)), "rand_peek");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
